// File: rtl/gesture_pkg.sv
// gesture_pkg: shared types, constants and helper functions for the gesture tracker.
// Optional feature macro used elsewhere: GESTURE_TRACKER_SMOOTH_EN.
package gesture_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] NOT_FOUND = 11'd2023;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4,
    DIR_LOST  = 3'd5
  } dir_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_TRACK,
    S_COOLDOWN
  } state_t;

  // Horizontal motion wins ties; a gesture needs at least thresh pixels on its axis.
  function automatic dir_t classifyDir(input logic signed [11:0] dx,
                                       input logic signed [11:0] dy,
                                       input int thresh);
    logic [11:0] absDx;
    logic [11:0] absDy;
    absDx = dx[11] ? 12'(-dx) : 12'(dx);
    absDy = dy[11] ? 12'(-dy) : 12'(dy);
    if ((absDx >= absDy) && (int'(absDx) >= thresh))
      return (dx > 12'sd0) ? DIR_RIGHT : DIR_LEFT;
    else if (int'(absDy) >= thresh)
      return (dy > 12'sd0) ? DIR_DOWN : DIR_UP;
    return DIR_NONE;
  endfunction

  // Linear extrapolation one frame ahead, clamped into [0, limit-1].
  function automatic logic [COORD_W-1:0] predictAxis(input logic [COORD_W-1:0] newest,
                                                     input logic [COORD_W-1:0] prev,
                                                     input int limit);
    logic signed [12:0] p;
    p = $signed({2'b00, newest}) + $signed({2'b00, newest}) - $signed({2'b00, prev});
    if (int'(p) < 0)
      return '0;
    else if (int'(p) > limit - 1)
      return COORD_W'(limit - 1);
    return p[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/gesture_hist_buf.sv
// gesture_hist_buf: circular register history of packed {x,y} centroids.
// Exposes the oldest, newest and previous entries plus the fill count.
module gesture_hist_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 22,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] oldest_o,
  output logic [DATA_W-1:0] newest_o,
  output logic [DATA_W-1:0] prev_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q;
  logic [CW-1:0]     count_q;

  // Write pointer always points at the oldest slot once the buffer is full, so a push overwrites it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (push_i) begin
      mem_q[wrPtr_q] <= data_i;
      wrPtr_q        <= wrPtr_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
    end
  end

  assign oldest_o = mem_q[wrPtr_q - count_q[AW-1:0]];
  assign newest_o = mem_q[wrPtr_q - AW'(1)];
  assign prev_o   = mem_q[wrPtr_q - AW'(2)];
  assign count_o  = count_q;

endmodule

// File: rtl/gesture_tracker.sv
// gesture_tracker: tracks detector centroids, predicts the next position and classifies gestures.
// Define GESTURE_TRACKER_SMOOTH_EN to low-pass filter present samples before use.
module gesture_tracker
  import gesture_pkg::*;
#(
  parameter int HIST_DEPTH  = 8,
  parameter int MOVE_THRESH = 48,
  parameter int LOST_LIMIT  = 4,
  parameter int COOLDOWN    = 8,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [10:0]        i_x,
  input  logic [10:0]        i_y,
  input  logic               i_clear,
  output logic               o_valid,
  output logic [2:0]         o_dir,
  output logic signed [11:0] o_dx,
  output logic signed [11:0] o_dy,
  output logic [10:0]        o_pred_x,
  output logic [10:0]        o_pred_y,
  output logic               o_tracking
);

  localparam int CW  = $clog2(HIST_DEPTH + 1);
  localparam int LW  = $clog2(LOST_LIMIT + 1);
  localparam int CDW = $clog2(COOLDOWN + 1);

  state_t state_q, stateD;
  logic [LW-1:0]  lost_q, lostD;
  logic [CDW-1:0] cool_q, coolD;
  logic pushD, flushD;

  logic valid_q, validD, tracking_q, trackingD;
  dir_t dir_q, dirD;
  logic signed [11:0] dx_q, dxD, dy_q, dyD;
  logic [10:0] predX_q, predXD, predY_q, predYD;

  logic [10:0] sampleX, sampleY;
  logic [21:0] oldest, newest, prev;
  logic [CW-1:0] histCount;
  logic missing, classifyNow, gesture, lostHit;
  logic signed [11:0] dx, dy;
  dir_t rawDir;

  assign missing = (i_x == NOT_FOUND) || (i_x >= 11'(WIDTH)) || (i_y >= 11'(HEIGHT));

`ifdef GESTURE_TRACKER_SMOOTH_EN
  logic [10:0] smX_q, smY_q;

  function automatic logic [10:0] smoothStep(input logic [10:0] s, input logic [10:0] in);
    logic signed [12:0] diff;
    logic signed [12:0] sum;
    diff = $signed({2'b00, in}) - $signed({2'b00, s});
    sum  = $signed({2'b00, s}) + (diff >>> 2);
    return sum[10:0];
  endfunction

  assign sampleX = (state_q == S_EMPTY) ? i_x : smoothStep(smX_q, i_x);
  assign sampleY = (state_q == S_EMPTY) ? i_y : smoothStep(smY_q, i_y);

  // Filter state follows every accepted sample; a fresh track reseeds it from the raw input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smX_q <= '0;
      smY_q <= '0;
    end else if (i_clear) begin
      smX_q <= '0;
      smY_q <= '0;
    end else if (i_valid && !missing && (state_q != S_COOLDOWN)) begin
      smX_q <= sampleX;
      smY_q <= sampleY;
    end
  end
`else
  assign sampleX = i_x;
  assign sampleY = i_y;
`endif

  gesture_hist_buf #(
    .DEPTH  (HIST_DEPTH),
    .DATA_W (22)
  ) u_hist (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .push_i   (pushD),
    .flush_i  (flushD),
    .data_i   ({sampleX, sampleY}),
    .oldest_o (oldest),
    .newest_o (newest),
    .prev_o   (prev),
    .count_o  (histCount)
  );

  assign dx          = $signed({1'b0, sampleX}) - $signed({1'b0, oldest[21:11]});
  assign dy          = $signed({1'b0, sampleY}) - $signed({1'b0, oldest[10:0]});
  assign rawDir      = classifyDir(dx, dy, MOVE_THRESH);
  assign classifyNow = (state_q == S_TRACK) ||
                       ((state_q == S_FILL) && (histCount == CW'(HIST_DEPTH - 1)));
  assign gesture     = classifyNow && (rawDir != DIR_NONE);
  assign lostHit     = (lost_q == LW'(LOST_LIMIT - 1));

  // State register together with the lost-frame and cooldown counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
      lost_q  <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= stateD;
      lost_q  <= lostD;
      cool_q  <= coolD;
    end
  end

  // Next-state logic: decides pushes, flushes and counter updates for each incoming sample.
  always_comb begin
    stateD = state_q;
    lostD  = lost_q;
    coolD  = cool_q;
    pushD  = 1'b0;
    flushD = 1'b0;
    if (i_clear) begin
      stateD = S_EMPTY;
      lostD  = '0;
      coolD  = '0;
      flushD = 1'b1;
    end else if (i_valid) begin
      if (state_q == S_COOLDOWN) begin
        coolD = cool_q - CDW'(1);
        if (cool_q <= CDW'(1)) stateD = S_EMPTY;
      end else if (missing) begin
        if (lostHit) begin
          lostD  = '0;
          flushD = 1'b1;
          stateD = S_EMPTY;
        end else begin
          lostD = lost_q + LW'(1);
        end
      end else begin
        lostD = '0;
        if (gesture) begin
          flushD = 1'b1;
          coolD  = CDW'(COOLDOWN);
          stateD = S_COOLDOWN;
        end else begin
          pushD  = 1'b1;
          stateD = classifyNow ? S_TRACK : S_FILL;
        end
      end
    end
  end

  // Output logic: the result set that will be registered alongside the next o_valid pulse.
  always_comb begin
    validD    = 1'b0;
    dirD      = dir_q;
    dxD       = dx_q;
    dyD       = dy_q;
    predXD    = predX_q;
    predYD    = predY_q;
    trackingD = tracking_q;
    if (i_clear) begin
      dirD      = DIR_NONE;
      dxD       = '0;
      dyD       = '0;
      predXD    = NOT_FOUND;
      predYD    = NOT_FOUND;
      trackingD = 1'b0;
    end else if (i_valid) begin
      validD = 1'b1;
      dirD   = DIR_NONE;
      dxD    = '0;
      dyD    = '0;
      if (state_q == S_COOLDOWN) begin
        predXD    = NOT_FOUND;
        predYD    = NOT_FOUND;
        trackingD = 1'b0;
      end else if (missing) begin
        if (lostHit || (histCount == '0)) begin
          dirD      = lostHit ? DIR_LOST : DIR_NONE;
          predXD    = NOT_FOUND;
          predYD    = NOT_FOUND;
          trackingD = 1'b0;
        end else begin
          predXD    = (histCount == CW'(1)) ? newest[21:11] : predictAxis(newest[21:11], prev[21:11], WIDTH);
          predYD    = (histCount == CW'(1)) ? newest[10:0]  : predictAxis(newest[10:0],  prev[10:0],  HEIGHT);
          trackingD = 1'b1;
        end
      end else begin
        if (classifyNow) begin
          dirD = rawDir;
          dxD  = dx;
          dyD  = dy;
        end
        if (gesture) begin
          predXD    = NOT_FOUND;
          predYD    = NOT_FOUND;
          trackingD = 1'b0;
        end else begin
          predXD    = (histCount == '0) ? sampleX : predictAxis(sampleX, newest[21:11], WIDTH);
          predYD    = (histCount == '0) ? sampleY : predictAxis(sampleY, newest[10:0],  HEIGHT);
          trackingD = 1'b1;
        end
      end
    end
  end

  // Result registers; they hold between valid pulses and return to idle values on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      dir_q      <= DIR_NONE;
      dx_q       <= '0;
      dy_q       <= '0;
      predX_q    <= NOT_FOUND;
      predY_q    <= NOT_FOUND;
      tracking_q <= 1'b0;
    end else begin
      valid_q    <= validD;
      dir_q      <= dirD;
      dx_q       <= dxD;
      dy_q       <= dyD;
      predX_q    <= predXD;
      predY_q    <= predYD;
      tracking_q <= trackingD;
    end
  end

  assign o_valid    = valid_q;
  assign o_dir      = dir_q;
  assign o_dx       = dx_q;
  assign o_dy       = dy_q;
  assign o_pred_x   = predX_q;
  assign o_pred_y   = predY_q;
  assign o_tracking = tracking_q;

endmodule

// File: tb/tb_gesture_tracker.sv
// tb_gesture_tracker: directed and randomized checks of gesture_tracker against a queue-based model.
// Exercises the default build (GESTURE_TRACKER_SMOOTH_EN undefined).
module tb_gesture_tracker;

  localparam int D      = 8;
  localparam int THRESH = 48;
  localparam int LOSTL  = 4;
  localparam int COOL   = 8;
  localparam int W      = 640;
  localparam int H      = 480;
  localparam int NF     = 2023;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_clear = 1'b0;
  logic [10:0] i_x = '0;
  logic [10:0] i_y = '0;
  logic o_valid, o_tracking;
  logic [2:0] o_dir;
  logic signed [11:0] o_dx, o_dy;
  logic [10:0] o_pred_x, o_pred_y;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  // Reference model state: the history is simply the list of retained samples, oldest first.
  int histX[$];
  int histY[$];
  int lostCnt, coolCnt;
  logic eValid, eTrack;
  int eDir, eDx, eDy, ePx, ePy;

  gesture_tracker #(
    .HIST_DEPTH  (D),
    .MOVE_THRESH (THRESH),
    .LOST_LIMIT  (LOSTL),
    .COOLDOWN    (COOL),
    .WIDTH       (W),
    .HEIGHT      (H)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_clear    (i_clear),
    .o_valid    (o_valid),
    .o_dir      (o_dir),
    .o_dx       (o_dx),
    .o_dy       (o_dy),
    .o_pred_x   (o_pred_x),
    .o_pred_y   (o_pred_y),
    .o_tracking (o_tracking)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s (cycle %0d): observed %0d expected %0d", tag, cycle, observed, expected);
    end
  endtask

  function automatic int clampAxis(input int v, input int limit);
    if (v < 0) return 0;
    if (v > limit - 1) return limit - 1;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelReset();
    histX.delete();
    histY.delete();
    lostCnt = 0;
    coolCnt = 0;
    eValid  = 1'b0;
    eDir    = 0;
    eDx     = 0;
    eDy     = 0;
    ePx     = NF;
    ePy     = NF;
    eTrack  = 1'b0;
  endtask

  task automatic modelStep(input logic v, input int x, input int y, input logic clr);
    bit miss;
    int n;
    eValid = 1'b0;
    if (clr) begin
      modelReset();
      return;
    end
    if (!v) return;
    eValid = 1'b1;
    eDir   = 0;
    eDx    = 0;
    eDy    = 0;
    miss   = (x == NF) || (x >= W) || (y >= H);
    if (coolCnt > 0) begin
      coolCnt--;
      ePx    = NF;
      ePy    = NF;
      eTrack = 1'b0;
    end else if (miss) begin
      lostCnt++;
      if (lostCnt == LOSTL) begin
        histX.delete();
        histY.delete();
        lostCnt = 0;
        eDir    = 5;
        ePx     = NF;
        ePy     = NF;
        eTrack  = 1'b0;
      end else begin
        eTrack = (histX.size() > 0);
      end
    end else begin
      lostCnt = 0;
      if (histX.size() >= D - 1) begin
        eDx = x - histX[0];
        eDy = y - histY[0];
        if (iabs(eDx) >= iabs(eDy) && iabs(eDx) >= THRESH) eDir = (eDx > 0) ? 4 : 3;
        else if (iabs(eDy) >= THRESH)                        eDir = (eDy > 0) ? 2 : 1;
      end
      if (eDir != 0) begin
        histX.delete();
        histY.delete();
        coolCnt = COOL;
        ePx     = NF;
        ePy     = NF;
        eTrack  = 1'b0;
      end else begin
        if (histX.size() == D) begin
          void'(histX.pop_front());
          void'(histY.pop_front());
        end
        histX.push_back(x);
        histY.push_back(y);
        n = histX.size();
        if (n == 1) begin
          ePx = x;
          ePy = y;
        end else begin
          ePx = clampAxis(2 * x - histX[n-2], W);
          ePy = clampAxis(2 * y - histY[n-2], H);
        end
        eTrack = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    logic [11:0] xdx, xdy;
    xdx = 12'(eDx);
    xdy = 12'(eDy);
    checkOutput("valid",    32'(o_valid),       32'(eValid));
    checkOutput("dir",      32'(o_dir),         32'(eDir));
    checkOutput("dx",       {20'b0, o_dx},      {20'b0, xdx});
    checkOutput("dy",       {20'b0, o_dy},      {20'b0, xdy});
    checkOutput("pred_x",   32'(o_pred_x),      32'(ePx));
    checkOutput("pred_y",   32'(o_pred_y),      32'(ePy));
    checkOutput("tracking", 32'(o_tracking),    32'(eTrack));
  endtask

  // One clock of stimulus: drive on the falling edge, sample just after the rising edge.
  task automatic applyStimulus(input logic v, input int x, input int y, input logic clr);
    @(negedge i_clk);
    i_valid = v;
    i_x     = 11'(x);
    i_y     = 11'(y);
    i_clear = clr;
    modelStep(v, x, y, clr);
    @(posedge i_clk);
    #1;
    cycle++;
    checkAll();
  endtask

  int px, py, vx, vy, r;

  initial begin
    modelReset();
    $display("[TB] reset phase");
    repeat (2) @(negedge i_clk);
    checkAll();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    $display("[TB] rightward sweep, cooldown, restart");
    for (int i = 0; i < 8; i++) applyStimulus(1, 100 + 10 * i, 240, 0);
    checkOutput("sweep_dir", 32'(o_dir), 32'd4);
    checkOutput("sweep_dx",  {20'b0, o_dx}, 32'd70);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 170, 240, 0);
      checkOutput("cool_track", 32'(o_tracking), 32'd0);
    end
    applyStimulus(1, 200, 210, 0);
    checkOutput("restart_track", 32'(o_tracking), 32'd1);
    checkOutput("restart_px",    32'(o_pred_x),   32'd200);

    $display("[TB] jitter stays NONE");
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1, 320, 240, 0);
      else            applyStimulus(1, 325, 236, 0);
      checkOutput("jitter_dir", 32'(o_dir), 32'd0);
    end
    checkOutput("jitter_dx", {20'b0, o_dx}, 32'd5);
    checkOutput("jitter_dy", {20'b0, o_dy}, 32'h0000_0FFC);

    $display("[TB] lost target");
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 300, 200, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, NF, NF, 0);
    checkOutput("lost_dir",   32'(o_dir),      32'd5);
    checkOutput("lost_px",    32'(o_pred_x),   32'd2023);
    checkOutput("lost_track", 32'(o_tracking), 32'd0);

    $display("[TB] brief loss keeps history");
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 300, 200, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, NF, NF, 0);
    applyStimulus(1, 300, 200, 0);
    applyStimulus(1, 300, 200, 0);
    checkOutput("keep_dir7", 32'(o_dir), 32'd0);
    applyStimulus(1, 360, 200, 0);
    checkOutput("keep_dir8", 32'(o_dir), 32'd4);

    $display("[TB] prediction clamp");
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 630, 240, 0);
    applyStimulus(1, 638, 240, 0);
    checkOutput("clamp_px", 32'(o_pred_x), 32'd639);
    checkOutput("clamp_py", 32'(o_pred_y), 32'd240);

    $display("[TB] clear beats valid");
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, 400, 300, 0);
    applyStimulus(1, 400, 300, 1);
    checkOutput("clear_valid", 32'(o_valid), 32'd0);
    applyStimulus(1, 50, 60, 0);
    checkOutput("clear_px", 32'(o_pred_x), 32'd50);
    checkOutput("clear_py", 32'(o_pred_y), 32'd60);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1, 60 + i, 70, 0);
    @(posedge i_clk);
    #2;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("[TB] randomized traffic");
    px = 320; py = 240; vx = 0; vy = 0;
    for (int it = 0; it < 3000; it++) begin
      r = int'($urandom_range(0, 99));
      if (r % 10 == 0) begin
        vx = int'($urandom_range(0, 30)) - 15;
        vy = int'($urandom_range(0, 30)) - 15;
      end
      if (r < 25) begin
        applyStimulus(0, px, py, 0);
      end else if (r < 33) begin
        case ($urandom_range(0, 2))
          0:       applyStimulus(1, NF, NF, 0);
          1:       applyStimulus(1, int'($urandom_range(640, 2047)), py, 0);
          default: applyStimulus(1, px, int'($urandom_range(480, 2047)), 0);
        endcase
      end else if (r < 35) begin
        applyStimulus(logic'($urandom_range(0, 1)), px, py, 1);
      end else begin
        if (r == 99) begin
          px = (($urandom_range(0, 1)) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(630, 639));
          py = (($urandom_range(0, 1)) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(470, 479));
        end else begin
          px = clampAxis(px + vx, W);
          py = clampAxis(py + vy, H);
        end
        applyStimulus(1, px, py, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
